// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle add/sub/logic/shift/compare plus an iterative
// shift-add multiplier. The result and flags are held until downstream takes them.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_cmd,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_AND = 4'd3,
                         CMD_OR  = 4'd4, CMD_XOR = 4'd5, CMD_SHL = 4'd6,
                         CMD_SHR = 4'd7, CMD_SRA = 4'd8, CMD_SLT = 4'd9,
                         CMD_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [3:0]           flags_q, flags_d;
  logic                 rdy_q;

  logic [SW-1:0]        sh;
  logic [WIDTH:0]       add_w, sub_w, mul_sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v, is_single, is_mul, accept;
  logic [2*WIDTH-1:0]   step;

  // rdy_q delays o_ready until the first edge after reset release.
  assign o_ready  = reset && rdy_q &&
                    (state_q == S_IDLE || (state_q == S_DONE && i_ready));
  assign accept   = i_valid && o_ready;
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;
  assign o_flags  = flags_q;

  always_comb begin
    sh        = i_b[SW-1:0];
    add_w     = {1'b0, i_a} + {1'b0, i_b};
    sub_w     = {1'b0, i_a} - {1'b0, i_b};
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    is_single = 1'b1;
    is_mul    = 1'b0;
    case (i_cmd)
      CMD_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (add_w[WIDTH-1] != i_a[WIDTH-1]);
      end
      CMD_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (sub_w[WIDTH-1] != i_a[WIDTH-1]);
      end
      CMD_AND: alu_res = i_a & i_b;
      CMD_OR:  alu_res = i_a | i_b;
      CMD_XOR: alu_res = i_a ^ i_b;
      CMD_SHL: alu_res = i_a << sh;
      CMD_SHR: alu_res = i_a >> sh;
      CMD_SRA: alu_res = $signed(i_a) >>> sh;
      CMD_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      CMD_MUL: begin
        is_single = 1'b0;
        is_mul    = MUL_EN;
      end
      default: is_single = 1'b0;
    endcase
  end

  // Multiplier bits sit in the low half and shift out as the partial product
  // accumulates in the high half.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    if (prod_q[0]) step = {mul_sum, prod_q[WIDTH-1:1]};
    else           step = {1'b0, prod_q[2*WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && i_ready) state_d = S_IDLE;
        if (accept) begin
          if (is_single) begin
            state_d = S_DONE;
            res_d   = alu_res;
            flags_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
          end else if (is_mul) begin
            state_d = S_BUSY;
            cnt_d   = CW'(WIDTH);
            prod_d  = {{WIDTH{1'b0}}, i_b};
            mcand_d = i_a;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BUSY: begin
        prod_d = step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = step[WIDTH-1:0];
          flags_d = {step[WIDTH-1], step[WIDTH-1:0] == '0,
                     step[2*WIDTH-1:WIDTH] != '0, 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle adder. Accepts one operation per valid/ready transfer, computes add/sub/logic/shift in one cycle and multiply iteratively. Results and status flags are held in an output register until the consumer accepts them. Sits between an instruction issue stage (upstream) and a writeback stage (downstream).

## Interface
- `WIDTH`, default 32: operand/result width; power of two, ≥ 8.
- `MUL_EN`, default 1: 1 = MUL implemented; 0 = MUL code treated as NOP.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is sampled on `clk`.
- `i_valid`  in  1  an operation is presented.
- `o_ready`  out  1  the block accepts an operation this cycle.
- `i_a`  in  WIDTH  1st operand.
- `i_b`  in  WIDTH  2nd operand; shifts use `i_b[$clog2(WIDTH)-1:0]` only.
- `i_cmd`  in  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical), 8 SRA, 9 SLT (signed, result 0/1), 10 MUL (low WIDTH bits); 11–15 reserved, treated as NOP.
- `o_valid`  out  1  result/flags valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_result`  out  WIDTH  result.
- `o_flags`  out  4  {N, Z, C, V}.

## Operation
- Transfer in: `i_valid && o_ready` at a rising edge. Operands and cmd are registered there; inputs are don't-care afterwards.
- Transfer out: `o_valid && i_ready` at a rising edge.
- States:
  - IDLE: no result held.
  - BUSY: MUL in progress, counter runs WIDTH down to 0.
  - DONE: result held.
- `o_ready = reset && (state==IDLE || (state==DONE && i_ready))`. Never high in BUSY.
- Transitions:
  - IDLE/DONE, on accept of a single-cycle op → DONE, with the new result loaded.
  - IDLE/DONE, on accept of MUL → BUSY.
  - IDLE/DONE, on accept of NOP or reserved → IDLE; no result is produced.
  - DONE with `i_ready` and no accept → IDLE.
  - DONE without `i_ready` → stays in DONE; `o_result`/`o_flags` are held bit-stable.
  - BUSY, counter reaches 0 → DONE.
- MUL: shift-add, one multiplier bit per cycle. The product is 2·WIDTH wide internally; `o_result` = low half.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a<b unsigned); V = signed overflow.
  - MUL: C = (high half ≠ 0); V = 0.
  - All other ops: C = V = 0.
- Reset: all outputs go to 0 (`o_valid`, `o_ready`, `o_result`, `o_flags`) and state goes to IDLE. Reset during BUSY or DONE discards the in-flight result.

## Timing
- Single-cycle ops: accepted at edge T, `o_valid` is high after edge T (latency 1).
- MUL: accepted at edge T, `o_valid` is high after edge T+WIDTH (latency WIDTH+1, i.e. 33 at WIDTH=32). `o_valid` is 0 throughout BUSY.
- Throughput: one single-cycle op per cycle while `i_ready` = 1 (DONE→DONE back-to-back).
- A result accepted downstream and a new op accepted upstream on the same edge are legal.
- `o_valid` never drops without a transfer out, except on reset.
- First `o_ready` = 1 is the cycle after the first rising edge with `reset` high.

## Test plan
- Reset: hold `reset`=0 with random inputs → `o_valid`=0, `o_ready`=0, `o_result`=0, `o_flags`=0. Release → `o_ready`=1 after one edge.
- ADD 0xFFFFFFFF+0x1 → result 0, flags Z=1, C=1, V=0, N=0, latency 1. SUB 0x80000000−0x1 → 0x7FFFFFFF, V=1, C=0. SUB 3−5 → 0xFFFFFFFE, N=1, C=1.
- Logic/shift: SRA 0x80000000 by 31 → 0xFFFFFFFF. SHL 0x1 by 0x24 (uses 4) → 0x10. SLT 0xFFFFFFFF vs 0x1 → 1.
- MUL 0x10000×0x10000 → result 0, Z=1, C=1, `o_valid` exactly 33 cycles after accept, `o_ready`=0 during BUSY. MUL 7×6 → 42, C=0. With `MUL_EN`=0 → no result.
- Back-pressure/throughput:
  - `i_ready`=0 for 5 cycles → result/flags stable and `o_ready`=0.
  - 8 back-to-back ADDs with `i_ready`=1 → 8 results on consecutive cycles, in order.
  - NOP/reserved cmd 12 → accepted, no `o_valid`.
- Reset mid-operation: assert `reset` 10 cycles into a MUL → immediate return to IDLE, no result ever appears. Next ADD 2+2 → 4 with latency 1.
